sd_block_arbiter: RTL and testbench

- Sequences the SPI SD-card interface (SDIF) and shares it between NREQ block-read requesters (e.g. PRG loader, CHR loader, save-RAM restore).
- Grants requesters round-robin, latches the granted sector address and starts one block read on SDIF.
- Streams the returned bytes, with a byte index, to the granted requester.
- Signals completion, short reads, overruns and stalls, then returns SDIF to idle for the next request.

---
 rtl/sd_ctrl_pkg.sv | 21 ++
 rtl/sd_block_arbiter_if.sv | 27 ++
 rtl/sd_block_arbiter_rr.sv | 44 ++++
 rtl/sd_block_arbiter.sv | 143 ++++++++++++++
 tb/tb_sd_block_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sd_ctrl_pkg.sv
// Shared constants for the SD block arbiter: FSM state encoding,
// default block size and counter widths.
package sd_ctrl_pkg;

    localparam int BLOCK_BYTES_DEF = 512;
    localparam int WD_W            = 24;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ISSUE  = 3'd1;
    localparam logic [2:0] S_STREAM = 3'd2;
    localparam logic [2:0] S_DONE   = 3'd3;
    localparam logic [2:0] S_ABORT  = 3'd4;

    // One extra bit so the count can reach BLOCK_BYTES itself.
    function automatic int cnt_width(input int bytes);
        return $clog2(bytes) + 1;
    endfunction

    localparam int CNT_W_DEF = cnt_width(BLOCK_BYTES_DEF);

endpackage

// File: rtl/sd_block_arbiter_if.sv
// Bundle of the SPI SD-card interface (SDIF) handshake signals.
// master: arbiter side (drives addr/begin_read); slave: SDIF side.
interface sd_block_arbiter_if;

    logic [31:0] sd_in_addr;
    logic        sd_begin_read;
    logic        sd_idle;
    logic        sd_valid_read;
    logic [7:0]  sd_byte;

    modport master (
        output sd_in_addr,
        output sd_begin_read,
        input  sd_idle,
        input  sd_valid_read,
        input  sd_byte
    );

    modport slave (
        input  sd_in_addr,
        input  sd_begin_read,
        output sd_idle,
        output sd_valid_read,
        output sd_byte
    );

endinterface

// File: rtl/sd_block_arbiter_rr.sv
// rr_arbiter: round-robin pick of the first request at or after ptr.
// Ports: clock/reset, req (levels), advance (load ptr), any, winner.
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [NREQ-1:0] req,
    input  logic            advance,
    output logic            any,
    output logic [IW-1:0]   winner
);

    logic [IW-1:0]     ptr;
    logic [2*NREQ-1:0] dbl;
    logic [NREQ-1:0]   rot;
    logic [IW:0]       sum;

    // Rotate so bit 0 is the pointer slot; the lowest set bit wins.
    always_comb begin
        dbl    = {req, req} >> ptr;
        rot    = dbl[NREQ-1:0];
        any    = |req;
        winner = '0;
        sum    = '0;
        for (int j = NREQ - 1; j >= 0; j--) begin
            if (rot[j]) begin
                sum = {1'b0, ptr} + (IW+1)'(j);
                if (sum >= (IW+1)'(NREQ))
                    sum = sum - (IW+1)'(NREQ);
                winner = sum[IW-1:0];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            ptr <= '0;
        else if (advance)
            ptr <= (winner == IW'(NREQ - 1)) ? '0 : winner + 1'b1;
    end

endmodule

// File: rtl/sd_block_arbiter.sv
// Shares one SDIF block reader between NREQ requesters, round-robin.
// Ports: clock/reset; req/addr in; grant, byte_valid/data/index,
// done, error out; sd (SDIF master side).
module sd_block_arbiter
    import sd_ctrl_pkg::*;
#(
    parameter int          NREQ        = 2,
    parameter int          BLOCK_BYTES = BLOCK_BYTES_DEF,
    parameter logic [23:0] TIMEOUT     = 24'd1_000_000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [32*NREQ-1:0] addr,
    output logic [NREQ-1:0]   grant,
    output logic              byte_valid,
    output logic [7:0]        byte_data,
    output logic [8:0]        byte_index,
    output logic [NREQ-1:0]   done,
    output logic              error,
    sd_block_arbiter_if.master sd
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = cnt_width(BLOCK_BYTES);
    localparam logic [CW-1:0]   FULL    = CW'(BLOCK_BYTES);
    localparam logic [WD_W-1:0] WD_LAST = TIMEOUT - 24'd1;

    logic [2:0]      state;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_n;
    logic [WD_W-1:0] wd;
    logic [WD_W-1:0] wd_inc;
    logic            wd_hit;
    logic            overrun;
    logic            ovr_n;
    logic            take;
    logic            drop;
    logic            good_end;
    logic            pick_any;
    logic            advance;
    logic [IW-1:0]   winner;
    logic [31:0]     win_addr;

    rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rr (
        .clock   (clock),
        .reset   (reset),
        .req     (req),
        .advance (advance),
        .any     (pick_any),
        .winner  (winner)
    );

    always_comb begin
        win_addr = '0;
        for (int i = 0; i < NREQ; i++)
            if (winner == IW'(i))
                win_addr = addr[32*i +: 32];
    end

    assign advance  = (state == S_IDLE) && sd.sd_idle && pick_any;
    assign sd.sd_begin_read = (state == S_ISSUE);

    assign wd_hit   = (wd >= WD_LAST);
    assign wd_inc   = (wd == TIMEOUT) ? wd : wd + 1'b1;

    // Bytes beyond the block are dropped and mark the read as overrun.
    assign take     = sd.sd_valid_read && (cnt < FULL);
    assign drop     = sd.sd_valid_read && (cnt >= FULL);
    assign cnt_n    = take ? cnt + 1'b1 : cnt;
    assign ovr_n    = overrun | drop;
    assign good_end = (cnt_n == FULL) && !ovr_n;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            grant         <= '0;
            done          <= '0;
            error         <= 1'b0;
            byte_valid    <= 1'b0;
            byte_data     <= '0;
            byte_index    <= '0;
            sd.sd_in_addr <= '0;
            cnt           <= '0;
            wd            <= '0;
            overrun       <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            done       <= '0;
            error      <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (advance) begin
                        grant         <= NREQ'(1) << winner;
                        sd.sd_in_addr <= win_addr;
                        cnt           <= '0;
                        wd            <= '0;
                        overrun       <= 1'b0;
                        state         <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (!sd.sd_idle) begin
                        wd    <= '0;
                        state <= S_STREAM;
                    end else begin
                        wd <= wd_inc;
                        if (wd_hit) begin
                            done  <= grant;
                            error <= 1'b1;
                            grant <= '0;
                            state <= S_ABORT;
                        end
                    end
                end
                S_STREAM: begin
                    if (take) begin
                        byte_valid <= 1'b1;
                        byte_data  <= sd.sd_byte;
                        byte_index <= 9'(cnt);
                    end
                    cnt     <= cnt_n;
                    overrun <= ovr_n;
                    wd      <= take ? '0 : wd_inc;
                    if (sd.sd_idle) begin
                        done  <= grant;
                        error <= !good_end;
                        grant <= '0;
                        state <= good_end ? S_DONE : S_ABORT;
                    end else if (!take && wd_hit) begin
                        done  <= grant;
                        error <= 1'b1;
                        grant <= '0;
                        state <= S_ABORT;
                    end
                end
                S_DONE, S_ABORT: state <= S_IDLE;
                default:         state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_block_arbiter.sv
// Scoreboard bench for sd_block_arbiter with a behavioural SDIF model.
// Stimulus pushes expected bytes/addresses/completions; a monitor pops.
module tb_sd_block_arbiter;
    import sd_ctrl_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  req;
    logic [63:0] addr;
    logic [1:0]  grant;
    logic [1:0]  done;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic [8:0]  byte_index;
    logic        error;

    sd_block_arbiter_if sdif();

    sd_block_arbiter #(
        .NREQ(2), .BLOCK_BYTES(512), .TIMEOUT(24'd100)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .req        (req),
        .addr       (addr),
        .grant      (grant),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_index (byte_index),
        .done       (done),
        .error      (error),
        .sd         (sdif)
    );

    initial forever #5 clock = ~clock;

    typedef struct { logic [1:0] g; logic [8:0] idx; logic [7:0] data; } exp_byte_t;
    typedef struct { logic [1:0] g; logic err; } exp_done_t;
    typedef struct { logic [1:0] g; logic [31:0] a; } exp_addr_t;

    exp_byte_t qb[$];
    exp_done_t qd[$];
    exp_addr_t qa[$];

    int cmp = 0;
    int mism = 0;
    int cyc = 0;
    int nb_seen = 0;
    int last_idx = -1;
    int br_cyc = 0;
    int br_rises = 0;
    int done_cyc = 0;
    int model_nbytes = 512;
    bit model_hang = 1'b0;
    bit model_kill = 1'b0;

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    // SDIF model: answers begin_read with a block of bytes i[7:0].
    initial begin
        sdif.sd_idle       = 1'b1;
        sdif.sd_valid_read = 1'b0;
        sdif.sd_byte       = 8'h00;
        forever begin
            @(negedge clock);
            if (sdif.sd_begin_read && !model_hang && !reset) begin
                sdif.sd_idle = 1'b0;
                repeat (3) @(negedge clock);
                for (int i = 0; i < model_nbytes && !model_kill; i++) begin
                    sdif.sd_valid_read = 1'b1;
                    sdif.sd_byte       = i[7:0];
                    @(negedge clock);
                    sdif.sd_valid_read = 1'b0;
                    @(negedge clock);
                end
                sdif.sd_idle = 1'b1;
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents an output.
    initial begin
        logic      br_q;
        exp_byte_t eb;
        exp_done_t ed;
        exp_addr_t ea;
        br_q = 1'b0;
        forever begin
            @(negedge clock);
            if (reset) begin
                br_q = 1'b0;
                continue;
            end
            if (grant != 2'b00) begin
                cmp++;
                if ($countones(grant) != 1) begin
                    mism++;
                    $display("FAIL grant_onehot: grant=%b required one-hot", grant);
                end
            end
            if (byte_valid) begin
                nb_seen++;
                last_idx = int'(byte_index);
                cmp++;
                if (qb.size() == 0) begin
                    mism++;
                    $display("FAIL byte_unexpected: idx=%0d data=%h required no byte",
                             byte_index, byte_data);
                end else begin
                    eb = qb.pop_front();
                    if (byte_index !== eb.idx || byte_data !== eb.data || grant !== eb.g) begin
                        mism++;
                        $display("FAIL byte: idx=%0d data=%h grant=%b required idx=%0d data=%h grant=%b",
                                 byte_index, byte_data, grant, eb.idx, eb.data, eb.g);
                    end
                end
            end
            if (done != 2'b00 || error) begin
                done_cyc = cyc;
                cmp++;
                if (qd.size() == 0) begin
                    mism++;
                    $display("FAIL done_unexpected: done=%b error=%b required none", done, error);
                end else begin
                    ed = qd.pop_front();
                    if (done !== ed.g || error !== ed.err) begin
                        mism++;
                        $display("FAIL done: done=%b error=%b required done=%b error=%b",
                                 done, error, ed.g, ed.err);
                    end
                end
            end
            if (sdif.sd_begin_read && !br_q) begin
                br_cyc = cyc;
                br_rises++;
                cmp++;
                if (qa.size() == 0) begin
                    mism++;
                    $display("FAIL begin_unexpected: addr=%h required none", sdif.sd_in_addr);
                end else begin
                    ea = qa.pop_front();
                    if (sdif.sd_in_addr !== ea.a || grant !== ea.g) begin
                        mism++;
                        $display("FAIL begin_addr: addr=%h grant=%b required addr=%h grant=%b",
                                 sdif.sd_in_addr, grant, ea.a, ea.g);
                    end
                end
            end
            br_q = sdif.sd_begin_read;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp++;
        if (act !== exp) begin
            mism++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic push_xfer(input int who, input logic [31:0] a, input int nb, input bit err);
        logic [1:0] g;
        g = (who == 0) ? 2'b01 : 2'b10;
        qa.push_back('{g: g, a: a});
        for (int i = 0; i < nb && i < 512; i++)
            qb.push_back('{g: g, idx: 9'(i), data: 8'(i)});
        qd.push_back('{g: g, err: err});
    endtask

    task automatic wait_done(input int n, input int budget);
        int seen;
        int t;
        seen = 0;
        t = 0;
        while (seen < n && t < budget) begin
            @(negedge clock);
            t++;
            if (done != 2'b00) begin
                seen++;
                if (seen == n) req = 2'b00;
            end
        end
        if (seen < n) begin
            cmp++;
            mism++;
            $display("FAIL wait_done: pulses=%0d required %0d", seen, n);
            req = 2'b00;
        end
    endtask

    task automatic chk_drained(input string name);
        chk(name, 32'(qb.size() + qd.size() + qa.size()), 32'd0);
    endtask

    initial begin
        int nb0;
        int br0;
        int t;
        reset = 1'b1;
        req   = 2'b00;
        addr  = 64'h0;
        repeat (3) @(negedge clock);

        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_byte_valid", 32'(byte_valid), 32'd0);
        chk("rst_begin", 32'(sdif.sd_begin_read), 32'd0);
        chk("rst_in_addr", sdif.sd_in_addr, 32'd0);
        chk("rst_state", 32'(dut.state), 32'(S_IDLE));
        reset = 1'b0;
        repeat (2) @(negedge clock);

        // Contention: grants alternate 0,1,0,1.
        addr = {32'h0000_4000, 32'h0000_0100};
        push_xfer(0, 32'h100, 512, 1'b0);
        push_xfer(1, 32'h4000, 512, 1'b0);
        push_xfer(0, 32'h100, 512, 1'b0);
        push_xfer(1, 32'h4000, 512, 1'b0);
        req = 2'b11;
        wait_done(4, 6000);
        repeat (3) @(negedge clock);
        chk("cont_grant_idle", 32'(grant), 32'd0);
        chk_drained("cont_drained");

        // Single request; addr change after grant must not matter.
        addr[31:0] = 32'h0000_0200;
        push_xfer(0, 32'h200, 512, 1'b0);
        nb0 = nb_seen;
        br0 = br_rises;
        req = 2'b01;
        repeat (20) @(negedge clock);
        addr[31:0] = 32'hDEAD_BEEF;
        wait_done(1, 3000);
        chk("single_addr_hold", sdif.sd_in_addr, 32'h200);
        chk("single_begins", 32'(br_rises - br0), 32'd1);
        chk("single_bytes", 32'(nb_seen - nb0), 32'd512);
        chk_drained("single_drained");
        repeat (2) @(negedge clock);

        // Short read: 300 bytes then idle.
        model_nbytes = 300;
        addr[31:0] = 32'h0000_0600;
        push_xfer(0, 32'h600, 300, 1'b1);
        req = 2'b01;
        wait_done(1, 3000);
        chk("short_last_idx", 32'(last_idx), 32'd299);
        repeat (2) @(negedge clock);
        chk("short_state_idle", 32'(dut.state), 32'(S_IDLE));
        chk_drained("short_drained");

        // Overrun: 513 bytes offered, 512 strobes.
        model_nbytes = 513;
        addr[31:0] = 32'h0000_0800;
        push_xfer(0, 32'h800, 513, 1'b1);
        nb0 = nb_seen;
        req = 2'b01;
        wait_done(1, 3000);
        chk("ovr_strobes", 32'(nb_seen - nb0), 32'd512);
        chk_drained("ovr_drained");
        repeat (2) @(negedge clock);

        // Timeout: SDIF never leaves idle.
        model_hang = 1'b1;
        addr[63:32] = 32'h0000_0A00;
        push_xfer(1, 32'hA00, 0, 1'b1);
        req = 2'b10;
        wait_done(1, 500);
        chk("timeout_cycles", 32'(done_cyc - br_cyc), 32'd100);
        chk_drained("timeout_drained");
        model_hang = 1'b0;
        model_nbytes = 512;
        repeat (2) @(negedge clock);

        // Reset after 10 bytes: no done, then a clean transfer.
        addr[31:0] = 32'h0000_1000;
        push_xfer(0, 32'h1000, 512, 1'b0);
        qd.delete(qd.size() - 1);
        nb0 = nb_seen;
        req = 2'b01;
        t = 0;
        while (nb_seen - nb0 < 10 && t < 2000) begin
            @(negedge clock);
            #1;
            t++;
        end
        chk("rst_mid_reached", 32'(nb_seen - nb0 >= 10), 32'd1);
        model_kill = 1'b1;
        reset = 1'b1;
        req = 2'b00;
        #1;
        chk("rst_mid_grant", 32'(grant), 32'd0);
        chk("rst_mid_done", 32'(done), 32'd0);
        chk("rst_mid_error", 32'(error), 32'd0);
        chk("rst_mid_byte_valid", 32'(byte_valid), 32'd0);
        chk("rst_mid_begin", 32'(sdif.sd_begin_read), 32'd0);
        chk("rst_mid_in_addr", sdif.sd_in_addr, 32'd0);
        chk("rst_mid_index", 32'(byte_index), 32'd0);
        qb.delete();
        repeat (2) @(negedge clock);
        reset = 1'b0;
        t = 0;
        while (!sdif.sd_idle && t < 50) begin
            @(negedge clock);
            t++;
        end
        chk("rst_model_idle", 32'(sdif.sd_idle), 32'd1);
        model_kill = 1'b0;
        repeat (30) @(negedge clock);

        addr[63:32] = 32'h0000_2000;
        push_xfer(1, 32'h2000, 512, 1'b0);
        nb0 = nb_seen;
        req = 2'b10;
        wait_done(1, 3000);
        chk("post_rst_bytes", 32'(nb_seen - nb0), 32'd512);
        chk_drained("post_rst_drained");
        repeat (5) @(negedge clock);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mism);
        $finish;
    end

endmodule
